// File: rtl/dht11_emulator.sv
// Purpose: sensor-side DHT11 emulator; answers a host start pulse on an open-drain line with the
//          80us/80us preamble and a 40-bit frame (hum_int, hum_frac, temp_int, temp_frac, checksum).
// Latency: pull-low begins RESP_DELAY_US after the host release, plus the 2-cycle input synchronizer.
// Backpressure: none; dropping enable aborts any frame and releases the line on the next clock.
// Ports: clock/reset (async, active-high); enable gates responses; hum_*/temp_* are the frame bytes;
//        inject_checksum_error flips checksum bit 0; transmission_line is the open-drain bus;
//        busy spans accepted start to end of the final low; start_seen/frame_done are 1-cycle pulses.
module dht11_emulator #(
  parameter int TICKS_PER_US  = 50,
  parameter int MIN_START_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_US       = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 27,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_frac,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_frac,
  input  logic       inject_checksum_error,
  inout  wire        transmission_line,
  output logic       busy,
  output logic       start_seen,
  output logic       frame_done
);

  localparam int MIN_START_CYC = MIN_START_US * TICKS_PER_US;
  localparam int TW            = $clog2(MIN_START_CYC + 1);

  // Phase end values are "length - 1": a phase lasts exactly its length in cycles.
  localparam logic [TW-1:0] TIMER_MAX      = '1;
  localparam logic [TW-1:0] MIN_START_T    = TW'(MIN_START_CYC);
  localparam logic [TW-1:0] RESP_DELAY_END = TW'(RESP_DELAY_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] RESP_END       = TW'(RESP_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT_LOW_END    = TW'(BIT_LOW_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT0_HIGH_END  = TW'(BIT0_HIGH_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT1_HIGH_END  = TW'(BIT1_HIGH_US * TICKS_PER_US - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] HOST_LOW   = 3'd1;
  localparam logic [2:0] RESP_DELAY = 3'd2;
  localparam logic [2:0] RESP_LOW   = 3'd3;
  localparam logic [2:0] RESP_HIGH  = 3'd4;
  localparam logic [2:0] BIT_LOW    = 3'd5;
  localparam logic [2:0] BIT_HIGH   = 3'd6;
  localparam logic [2:0] END_LOW    = 3'd7;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [5:0]    bit_cnt;
  logic [39:0]   frame_sr;
  logic          drive_low;
  logic          line_meta;
  logic          line_sync;
  logic [7:0]    checksum;
  logic [TW-1:0] bit_high_end;

  assign transmission_line = drive_low ? 1'b0 : 1'bz;

  assign checksum     = (hum_int + hum_frac + temp_int + temp_frac) ^ {7'd0, inject_checksum_error};
  assign bit_high_end = frame_sr[39] ? BIT1_HIGH_END : BIT0_HIGH_END;

  // Synchronizer resets to the idle (pulled-up) level so reset never looks like a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      line_meta <= transmission_line;
      line_sync <= line_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      start_seen <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      start_seen <= 1'b0;
      frame_done <= 1'b0;
      if (timer != TIMER_MAX) timer <= timer + 1'b1;

      if (!enable && state != IDLE) begin
        state     <= IDLE;
        drive_low <= 1'b0;
        busy      <= 1'b0;
        timer     <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (enable && !line_sync) state <= HOST_LOW;
          end
          HOST_LOW: begin
            // Timer runs (saturating) while the host holds the line low.
            if (line_sync) begin
              timer <= '0;
              if (timer >= MIN_START_T) begin
                state      <= RESP_DELAY;
                start_seen <= 1'b1;
                busy       <= 1'b1;
                frame_sr   <= {hum_int, hum_frac, temp_int, temp_frac, checksum};
              end else begin
                state <= IDLE;
              end
            end
          end
          RESP_DELAY: if (timer == RESP_DELAY_END) begin
            state     <= RESP_LOW;
            drive_low <= 1'b1;
            timer     <= '0;
          end
          RESP_LOW: if (timer == RESP_END) begin
            state     <= RESP_HIGH;
            drive_low <= 1'b0;
            timer     <= '0;
          end
          RESP_HIGH: if (timer == RESP_END) begin
            state     <= BIT_LOW;
            drive_low <= 1'b1;
            bit_cnt   <= '0;
            timer     <= '0;
          end
          BIT_LOW: if (timer == BIT_LOW_END) begin
            state     <= BIT_HIGH;
            drive_low <= 1'b0;
            timer     <= '0;
          end
          BIT_HIGH: if (timer == bit_high_end) begin
            frame_sr  <= {frame_sr[38:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            drive_low <= 1'b1;
            timer     <= '0;
            state     <= (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
          end
          END_LOW: if (timer == BIT_LOW_END) begin
            state      <= IDLE;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            timer      <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// Purpose: self-checking bench for dht11_emulator; a host model drives start pulses and decodes frames.
// Latency: frames are measured phase by phase at falling clock edges against protocol timings.
// Backpressure: not applicable; every line wait is bounded and a timeout counts as an error.
module tb_dht11_emulator;

  localparam int TICKS      = 2;
  localparam int MIN_US     = 100;
  localparam int RESP_CYC   = 80 * TICKS;
  localparam int BITLOW_CYC = 50 * TICKS;
  localparam int BIT_THRESH = ((27 + 70) * TICKS) / 2;
  localparam int WAIT_LIM   = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] hum_int = 8'h00, hum_frac = 8'h00, temp_int = 8'h00, temp_frac = 8'h00;
  logic       inject_checksum_error = 1'b0;
  logic       busy, start_seen, frame_done;
  logic       host_low = 1'b0;
  wire        line;

  pullup (line);
  assign line = host_low ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;
  int ss_cnt = 0;
  int fd_cnt = 0;
  int poke_bit = -1;
  logic [7:0] poke_val = 8'h00;

  dht11_emulator #(.TICKS_PER_US(TICKS), .MIN_START_US(MIN_US)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .hum_int               (hum_int),
    .hum_frac              (hum_frac),
    .temp_int              (temp_int),
    .temp_frac             (temp_frac),
    .inject_checksum_error (inject_checksum_error),
    .transmission_line     (line),
    .busy                  (busy),
    .start_seen            (start_seen),
    .frame_done            (frame_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (start_seen) ss_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: four bytes then their sum mod 256, bit 0 flipped on injection.
  function automatic logic [39:0] model_frame(input int h, input int hf, input int t, input int tf,
                                              input bit inj);
    int sum;
    sum = (h + hf + t + tf) % 256;
    if (inj) sum = sum ^ 1;
    return {8'(h), 8'(hf), 8'(t), 8'(tf), 8'(sum)};
  endfunction

  // Called right after the sample that showed a new level; returns how many samples it lasted.
  task automatic wait_lvl(input logic lvl, input int limit, output int cnt, output bit to);
    cnt = 1;
    to  = 1'b0;
    forever begin
      @(negedge clock);
      if (line === lvl) break;
      cnt++;
      if (cnt > limit) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic host_start(input int low_us);
    @(negedge clock);
    host_low = 1'b1;
    repeat (low_us * TICKS) @(negedge clock);
    host_low = 1'b0;
  endtask

  // Issues a start and decodes the reply; stops at the start of bit abort_bit's low phase.
  task automatic run_frame(input int low_us, input int abort_bit, output logic [39:0] data,
                           output bit ok);
    int n;
    bit to;
    int bad_low;
    data    = '0;
    ok      = 1'b0;
    bad_low = 0;
    host_start(low_us);
    wait_lvl(1'b0, WAIT_LIM, n, to);
    if (to) begin chk("resp_timeout", 1, 0); return; end
    wait_lvl(1'b1, WAIT_LIM, n, to);
    chk("resp_low", n, RESP_CYC);
    if (to) return;
    chk("busy_on", busy, 1);
    wait_lvl(1'b0, WAIT_LIM, n, to);
    chk("resp_high", n, RESP_CYC);
    if (to) return;
    for (int i = 0; i < 40; i++) begin
      if (i == abort_bit) begin ok = 1'b1; return; end
      if (i == poke_bit) temp_int = poke_val;
      wait_lvl(1'b1, WAIT_LIM, n, to);
      if (to) begin chk("bit_low_timeout", 1, 0); return; end
      if (n != BITLOW_CYC) bad_low++;
      wait_lvl(1'b0, WAIT_LIM, n, to);
      if (to) begin chk("bit_high_timeout", 1, 0); return; end
      data = {data[38:0], (n > BIT_THRESH)};
    end
    chk("bit_low_len", bad_low, 0);
    wait_lvl(1'b1, WAIT_LIM, n, to);
    chk("end_low", n, BITLOW_CYC);
    if (to) return;
    ok = 1'b1;
  endtask

  task automatic full_frame(input string tag, input int low_us, input logic [7:0] h,
                            input logic [7:0] hf, input logic [7:0] t, input logic [7:0] tf,
                            input bit inj, input int pbit, input logic [7:0] pval);
    logic [39:0] got;
    bit ok;
    int ss0, fd0;
    @(negedge clock);
    hum_int = h; hum_frac = hf; temp_int = t; temp_frac = tf;
    inject_checksum_error = inj;
    poke_bit = pbit;
    poke_val = pval;
    ss0 = ss_cnt;
    fd0 = fd_cnt;
    run_frame(low_us, -1, got, ok);
    repeat (4) @(negedge clock);
    chk({tag, "_data"}, got, model_frame(h, hf, t, tf, inj));
    chk({tag, "_start_seen"}, ss_cnt - ss0, 1);
    chk({tag, "_frame_done"}, fd_cnt - fd0, 1);
    chk({tag, "_busy_off"}, busy, 0);
    poke_bit = -1;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    logic [39:0] got;
    bit ok, to;
    int n, ss0, fd0, lowc, busyc;

    repeat (3) @(negedge clock);
    chk("rst_line", line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start_seen", start_seen, 0);
    chk("rst_frame_done", frame_done, 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clock);

    full_frame("basic", 120, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, -1, 8'h00);

    // Host pulse shorter than the minimum start is a glitch.
    ss0 = ss_cnt;
    host_start(50);
    lowc = 0; busyc = 0;
    repeat (600) begin
      @(negedge clock);
      if (line === 1'b0) lowc++;
      if (busy) busyc++;
    end
    chk("short_line_low", lowc, 0);
    chk("short_busy", busyc, 0);
    chk("short_start_seen", ss_cnt - ss0, 0);

    // Checksum wrap; 130us also runs the start timer into saturation.
    full_frame("wrap", 130, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 8'h00);
    full_frame("inject", 120, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, -1, 8'h00);

    // Asynchronous reset during bit 10 low phase.
    hum_int = 8'h12; hum_frac = 8'h34; temp_int = 8'h56; temp_frac = 8'h78;
    inject_checksum_error = 1'b0;
    run_frame(120, 10, got, ok);
    chk("rst_mid_reached", ok, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_line", line, 1);
    chk("rst_mid_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    full_frame("after_rst", 120, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, -1, 8'h00);

    // Disabled emulator ignores a valid start.
    enable = 1'b0;
    ss0 = ss_cnt;
    host_start(120);
    lowc = 0;
    repeat (600) begin
      @(negedge clock);
      if (line === 1'b0) lowc++;
    end
    chk("dis_line_low", lowc, 0);
    chk("dis_start_seen", ss_cnt - ss0, 0);
    enable = 1'b1;
    repeat (10) @(negedge clock);

    // Enable dropped during a bit high phase.
    fd0 = fd_cnt;
    run_frame(120, 7, got, ok);
    chk("drop_reached", ok, 1);
    wait_lvl(1'b1, WAIT_LIM, n, to);
    chk("drop_high_seen", to, 0);
    repeat (3) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    chk("drop_busy", busy, 0);
    lowc = 0;
    repeat (400) begin
      @(negedge clock);
      if (line === 1'b0) lowc++;
    end
    chk("drop_line_low", lowc, 0);
    chk("drop_frame_done", fd_cnt - fd0, 0);
    enable = 1'b1;
    repeat (10) @(negedge clock);

    // temp_int changes during bit 5: in-flight frame keeps the latched byte.
    full_frame("midchg", 120, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 5, 8'h20);
    chk("midchg_input", temp_int, 8'h20);
    full_frame("next", 120, 8'h37, 8'h00, 8'h20, 8'h05, 1'b0, -1, 8'h00);

    repeat (2) begin
      full_frame("rand", int'($urandom_range(105, 140)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), -1, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
